// File: rtl/exp_sweep_ctrl.sv
// Exhaustive sweep engine: steps every input vector through a combinational block,
// captures its truth table and compares it against a latched expected table.
module exp_sweep_ctrl #(
    parameter int  N_IN   = 4,
    parameter int  SETTLE = 1,
    localparam int V      = 2**N_IN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [V-1:0]    expected,
    output logic [N_IN-1:0] vec,
    input  logic            y_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [V-1:0]    truth_table,
    output logic [N_IN:0]   mismatch_cnt,
    output logic [N_IN-1:0] first_fail,
    output logic            fail_valid
);
    typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, FIN} state_t;

    localparam logic [3:0]      SETTLE_C = 4'(SETTLE);
    localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};

    state_t          state_q, state_d;
    logic [V-1:0]    exp_q;
    logic [N_IN-1:0] idx_q;
    logic [3:0]      cnt_q;
    logic [1:0]      rst_sync;
    logic            rst_i_n;
    logic            miss;
    logic [N_IN:0]   mc_nxt;

    // Assert asynchronously, release on a clock edge so no flop sees a runt release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_i_n = rst_sync[1];

    assign vec    = idx_q;
    assign miss   = y_in ^ exp_q[idx_q];
    assign mc_nxt = mismatch_cnt + {{N_IN{1'b0}}, miss};

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE:   if (start) state_d = WAIT;
            WAIT: begin
                busy = 1'b1;
                if (cnt_q <= 4'd1) state_d = SAMPLE;
            end
            SAMPLE: begin
                busy    = 1'b1;
                state_d = (idx_q == IDX_LAST) ? FIN : WAIT;
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            exp_q        <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            truth_table  <= '0;
            mismatch_cnt <= '0;
            first_fail   <= '0;
            fail_valid   <= 1'b0;
            pass         <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    exp_q        <= expected;
                    idx_q        <= '0;
                    cnt_q        <= SETTLE_C;
                    truth_table  <= '0;
                    mismatch_cnt <= '0;
                    first_fail   <= '0;
                    fail_valid   <= 1'b0;
                    pass         <= 1'b0;
                end
                WAIT: cnt_q <= cnt_q - 4'd1;
                SAMPLE: begin
                    truth_table[idx_q] <= y_in;
                    mismatch_cnt       <= mc_nxt;
                    if (miss && !fail_valid) begin
                        first_fail <= idx_q;
                        fail_valid <= 1'b1;
                    end
                    // pass is settled here so it is already valid during the done cycle
                    if (idx_q == IDX_LAST) begin
                        pass <= (mc_nxt == '0);
                    end else begin
                        idx_q <= idx_q + 1'b1;
                        cnt_q <= SETTLE_C;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_exp_sweep_ctrl.sv
// Scoreboard bench for exp_sweep_ctrl: directed sweeps against stub expression blocks.
module tb_exp_sweep_ctrl;
    typedef struct {
        logic [15:0] tt;
        logic [4:0]  mc;
        logic [3:0]  ff;
        logic        fv;
        logic        pass;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0, n_bad = 0;
    exp_t q1[$], q3[$];

    // DUT 1: SETTLE=1, combinational stub (or constant 0)
    logic        start1 = 1'b0, y1, zero_mode = 1'b0;
    logic [15:0] exp1 = '0;
    logic [3:0]  vec1, ff1;
    logic        busy1, done1, pass1, fv1;
    logic [15:0] tt1;
    logic [4:0]  mc1;

    // DUT 3: SETTLE=3, stub with 2-cycle output delay
    logic        start3 = 1'b0, y3, d1 = 1'b0, d2 = 1'b0;
    logic [15:0] exp3 = '0;
    logic [3:0]  vec3, ff3;
    logic        busy3, done3, pass3, fv3;
    logic [15:0] tt3;
    logic [4:0]  mc3;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic f_abcd(input logic [3:0] v);
        return (v[3] & v[2]) | (v[1] & v[0]);
    endfunction

    assign y1 = zero_mode ? 1'b0 : f_abcd(vec1);
    always @(posedge clk) begin
        d1 <= f_abcd(vec3);
        d2 <= d1;
    end
    assign y3 = d2;

    exp_sweep_ctrl #(.N_IN(4), .SETTLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start1), .expected(exp1), .vec(vec1), .y_in(y1),
        .busy(busy1), .done(done1), .pass(pass1), .truth_table(tt1), .mismatch_cnt(mc1),
        .first_fail(ff1), .fail_valid(fv1));

    exp_sweep_ctrl #(.N_IN(4), .SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .expected(exp3), .vec(vec3), .y_in(y3),
        .busy(busy3), .done(done3), .pass(pass3), .truth_table(tt3), .mismatch_cnt(mc3),
        .first_fail(ff3), .fail_valid(fv3));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] tt, input logic [4:0] mc, input logic [3:0] ff,
                                input logic fv, input logic pass);
        exp_t e;
        e.tt = tt; e.mc = mc; e.ff = ff; e.fv = fv; e.pass = pass; e.due = 0;
        return e;
    endfunction

    task automatic cmp_result(input string tag, input exp_t e, input logic [15:0] tt, input logic [4:0] mc,
                              input logic [3:0] ff, input logic fv, input logic pass, input logic busy);
        chk({tag, ".truth_table"}, 32'(tt), 32'(e.tt));
        chk({tag, ".mismatch_cnt"}, 32'(mc), 32'(e.mc));
        chk({tag, ".first_fail"}, 32'(ff), 32'(e.ff));
        chk({tag, ".fail_valid"}, 32'(fv), 32'(e.fv));
        chk({tag, ".pass"}, 32'(pass), 32'(e.pass));
        chk({tag, ".busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, ".done_cycle"}, 32'(cyc), 32'(e.due));
    endtask

    always @(negedge clk) begin : mon1
        exp_t e;
        if (done1) begin
            if (q1.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL dut1.unexpected_done: got done at cycle %0d want none", cyc);
            end else begin
                e = q1.pop_front();
                cmp_result("dut1", e, tt1, mc1, ff1, fv1, pass1, busy1);
                chk("dut1.vec_after", 32'(vec1), 32'd15);
            end
        end
    end

    always @(negedge clk) begin : mon3
        exp_t e;
        if (done3) begin
            if (q3.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL dut3.unexpected_done: got done at cycle %0d want none", cyc);
            end else begin
                e = q3.pop_front();
                cmp_result("dut3", e, tt3, mc3, ff3, fv3, pass3, busy3);
            end
        end
    end

    // Pulse start on dut1; push the expectation with done due 32 edges after acceptance.
    task automatic go1(input logic [15:0] ex, input exp_t e, output int acc);
        @(negedge clk);
        exp1 = ex; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        acc = cyc;
        e.due = acc + 32;
        q1.push_back(e);
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 400 && (q1.size() > 0 || q3.size() > 0); i++) @(negedge clk);
        if (q1.size() > 0 || q3.size() > 0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s.timeout: got %0d pending want 0", nm, q1.size() + q3.size());
            q1.delete(); q3.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".vec"}, 32'(vec1), 0);
        chk({nm, ".busy"}, 32'(busy1), 0);
        chk({nm, ".done"}, 32'(done1), 0);
        chk({nm, ".tt"}, 32'(tt1), 0);
        chk({nm, ".mc"}, 32'(mc1), 0);
        chk({nm, ".ff"}, 32'(ff1), 0);
        chk({nm, ".fv"}, 32'(fv1), 0);
        chk({nm, ".pass"}, 32'(pass1), 0);
    endtask

    initial begin
        int acc;
        exp_t e;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        chk("reset.dut3_busy", 32'(busy3), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 1: a&b|c&d matches F888; vec walks 0..15 with two cycles per vector
        go1(16'hF888, mk(16'hF888, 5'd0, 4'd0, 1'b0, 1'b1), acc);
        for (int i = 0; i < 16; i++) begin
            chk("t1.vec_lo", 32'(vec1), 32'(i));
            @(negedge clk);
            chk("t1.vec_hi", 32'(vec1), 32'(i));
            @(negedge clk);
        end
        drain("t1");

        // 2: single differing bit at vector 0
        go1(16'hF889, mk(16'hF888, 5'd1, 4'd0, 1'b1, 1'b0), acc);
        drain("t2");

        // 3: all 16 vectors fail, count reaches 16 without wrapping
        zero_mode = 1'b1;
        go1(16'hFFFF, mk(16'h0000, 5'd16, 4'd0, 1'b1, 1'b0), acc);
        drain("t3");
        zero_mode = 1'b0;

        // first failure deep in the table: expected bit 12 cleared
        go1(16'hE888, mk(16'hF888, 5'd1, 4'd12, 1'b1, 1'b0), acc);
        drain("t3b");

        // 4: restart and expected change mid-sweep are ignored
        go1(16'hF888, mk(16'hF888, 5'd0, 4'd0, 1'b0, 1'b1), acc);
        for (int i = 0; i < 100 && vec1 != 4'd5; i++) @(negedge clk);
        chk("t4.reach_vec5", 32'(vec1), 32'd5);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        exp1 = 16'h0000;
        drain("t4");

        // start held high: back-to-back sweeps, second accepted two edges after done
        @(negedge clk);
        exp1 = 16'hF888; start1 = 1'b1;
        @(negedge clk);
        acc = cyc;
        e = mk(16'hF888, 5'd0, 4'd0, 1'b0, 1'b1);
        e.due = acc + 32; q1.push_back(e);
        e.due = acc + 66; q1.push_back(e);
        while (cyc < acc + 34) @(negedge clk);
        start1 = 1'b0;
        drain("hold");

        // 5: reset mid-sweep clears everything at once, no done pulse
        go1(16'hF889, mk(16'hF888, 5'd1, 4'd0, 1'b1, 1'b0), acc);
        for (int i = 0; i < 100 && vec1 != 4'd9; i++) @(negedge clk);
        chk("t5.reach_vec9", 32'(vec1), 32'd9);
        #2 rst_n = 1'b0;
        #1 chk_zero("t5.async");
        q1.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        go1(16'hF888, mk(16'hF888, 5'd0, 4'd0, 1'b0, 1'b1), acc);
        chk("t5.fresh_vec", 32'(vec1), 32'd0);
        drain("t5");

        // 6: SETTLE=3 tolerates a 2-cycle delayed stub; done 64 edges after acceptance
        @(negedge clk);
        exp3 = 16'hF888; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        e = mk(16'hF888, 5'd0, 4'd0, 1'b0, 1'b1);
        e.due = cyc + 64;
        q3.push_back(e);
        exp3 = 16'h1234;
        drain("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
